// File: rtl/des_stream_top.sv
// DES streaming engine: 16-stage unrolled Feistel pipeline fed by an
// iterative key scheduler that fills 16 subkey slots, one per clock.

// One pipelined Feistel round: L' = R, R' = L ^ f(R, K).
module des_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] lr_in,
  input  logic [47:0] k,
  output logic [63:0] lr_q
);
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  // S1..S8 back to back, 64 nibbles per box, row-major, first entry at the MSB.
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] kk);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ kk;
    // {outer bits, inner bits} of each 6-bit group is exactly row*16+col
    for (int j = 0; j < 8; j++) begin
      b   = x[47-6*j -: 6];
      idx = j*64 + int'({b[5], b[0], b[4:1]});
      s[31-4*j -: 4] = SBOX[2047-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  // round register; halves are swapped on the way in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lr_q <= '0;
    else        lr_q <= {lr_in[31:0], lr_in[63:32] ^ f_fn(lr_in[31:0], k)};
endmodule

module des_stream_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        encrypt,
  input  logic [63:0] keys_64_in,
  input  logic        change_keys_en,
  output logic        subkeys_16_valid,
  input  logic        data_input_en,
  input  logic [63:0] data_64_in,
  output logic [63:0] data_64_out,
  output logic        data_output_valid
);
  localparam int STAGES = 17;   // input IP register + 16 rounds; output reg is vld_pipe[STAGES]

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_fn(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [55:0] pc1_fn(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction

  typedef enum logic {IDLE, GEN} ks_state_t;

  ks_state_t         st, st_nx;
  logic [4:0]        cnt, slot;
  logic [55:0]       cd, cd_rot;
  logic              mode, kv, load, one_sh;
  logic [16:1][47:0] ks;

  assign load             = (st == IDLE) && kv && change_keys_en;
  assign subkeys_16_valid = kv;

  // scheduler next state
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (load) st_nx = GEN;
      GEN:     if (cnt == 5'd16) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // per-round C/D rotation and the slot the new subkey lands in
  always_comb begin
    one_sh = (cnt == 5'd1) || (cnt == 5'd2) || (cnt == 5'd9) || (cnt == 5'd16);
    cd_rot = one_sh ? {cd[54:28], cd[55], cd[26:0], cd[27]}
                    : {cd[53:28], cd[55:54], cd[25:0], cd[27:26]};
    slot   = mode ? cnt : 5'd17 - cnt;
  end

  // scheduler state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;

  // key capture, one subkey per GEN cycle; ready flag rises the edge after K16
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cd   <= '0;
      cnt  <= '0;
      mode <= 1'b1;
      kv   <= 1'b1;
      ks   <= '0;
    end else if (load) begin
      cd   <= pc1_fn(keys_64_in);
      mode <= encrypt;
      cnt  <= 5'd1;
      kv   <= 1'b0;
    end else if (st == GEN) begin
      cd       <= cd_rot;
      ks[slot] <= pc2_fn(cd_rot);
      cnt      <= cnt + 5'd1;
    end else begin
      kv <= 1'b1;
    end

  logic [STAGES:0] vld_pipe;
  logic [63:0]     chain [17];

  // valid tokens only enter while the subkeys are complete
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], data_input_en & kv};

  // input stage: initial permutation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain[0] <= '0;
    else        chain[0] <= ip_fn(data_64_in);

  for (genvar n = 1; n <= 16; n++) begin : g_rnd
    des_round u_rnd (
      .clk   (clk),
      .rst_n (rst_n),
      .lr_in (chain[n-1]),
      .k     (ks[n]),
      .lr_q  (chain[n])
    );
  end

  // output stage: undo last swap, FP; holds between results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)             data_64_out <= '0;
    else if (vld_pipe[16])  data_64_out <= fp_fn({chain[16][31:0], chain[16][63:32]});

  assign data_output_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_des_stream_top.sv
// Randomised stream bench for des_stream_top against a behavioural DES model.
module tb_des_stream_top;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        encrypt = 1'b1, change_keys_en = 1'b0, data_input_en = 1'b0;
  logic [63:0] keys_64_in = '0, data_64_in = '0;
  logic        subkeys_16_valid, data_output_valid;
  logic [63:0] data_64_out;

  always #5 clk = ~clk;

  des_stream_top dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .encrypt           (encrypt),
    .keys_64_in        (keys_64_in),
    .change_keys_en    (change_keys_en),
    .subkeys_16_valid  (subkeys_16_valid),
    .data_input_en     (data_input_en),
    .data_64_in        (data_64_in),
    .data_64_out       (data_64_out),
    .data_output_valid (data_output_valid)
  );

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  int total = 0, bad = 0, cyc = 0, ov_cnt = 0;
  typedef struct { logic [63:0] val; int due; } exp_t;
  exp_t        q[$];
  logic [63:0] cur_key = '0, last_out = '0, ct2;
  bit          cur_enc = 1'b1, kv_exp = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, o;
    int row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      row = 2*int'(x[47-6*b]) + int'(x[42-6*b]);
      col = int'(x[46-6*b -: 4]);
      s[31-4*b -: 4] = 4'(SB[b][row*16+col]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  // full DES: build all 16 subkeys, run them forward or reversed, FP as inverse of IP
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit enc);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] lr, o;
    logic [31:0] l, r, t;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28]; d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) lr[63-i] = blk[64-IP_T[i]];
    l = lr[63:32]; r = lr[31:0];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ f_ref(r, enc ? ks[n] : ks[15-n]);
      l = t;
    end
    lr = {r, l};
    for (int i = 0; i < 64; i++) o[64-IP_T[i]] = lr[63-i];
    return o;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: valid exactly when a result is due, data matches, output holds otherwise
  always @(negedge clk) begin
    bit exp_v;
    if (rst_n) begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      if (data_output_valid) ov_cnt++;
      chk("out_valid", 64'(data_output_valid), 64'(exp_v));
      if (exp_v) begin
        chk("out_data", data_64_out, q[0].val);
        last_out = q[0].val;
        void'(q.pop_front());
      end else begin
        chk("out_hold", data_64_out, last_out);
      end
    end
  end

  task automatic tick(input bit en, input logic [63:0] blk, input bit strobe);
    exp_t e;
    data_input_en = en; data_64_in = blk; change_keys_en = strobe;
    @(posedge clk); #1;
    if (en && kv_exp) begin
      e.val = des_ref(cur_key, blk, cur_enc);
      e.due = cyc + 17;
      q.push_back(e);
    end
    data_input_en = 1'b0; change_keys_en = 1'b0;
  endtask

  task automatic drain();
    repeat (20) tick(1'b0, '0, 1'b0);
  endtask

  // strobe a key; optionally poke strobe/data during GEN, which must be ignored
  task automatic load_key(input logic [63:0] key, input bit enc, input bit noise);
    keys_64_in = key; encrypt = enc;
    tick(1'b0, '0, 1'b1);
    cur_key = key; cur_enc = enc; kv_exp = 1'b0;
    chk("kv_drop", 64'(subkeys_16_valid), 64'(0));
    for (int i = 1; i <= 17; i++) begin
      if (noise && i == 5) begin keys_64_in = ~key; encrypt = ~enc; end
      tick(noise && i >= 3 && i <= 6, {$urandom, $urandom}, noise && i == 5);
      chk("kv_gen", 64'(subkeys_16_valid), 64'(i == 17));
    end
    kv_exp = 1'b1;
  endtask

  task automatic async_rst();
    bit exp_v;
    @(posedge clk); #2;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("pre_rst_valid", 64'(data_output_valid), 64'(exp_v));
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(data_output_valid), 64'(0));
    chk("rst_kv", 64'(subkeys_16_valid), 64'(1));
    chk("rst_dout", data_64_out, 64'(0));
    q.delete(); last_out = '0; kv_exp = 1'b1; cur_key = '0; cur_enc = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_kv", 64'(subkeys_16_valid), 64'(1));
    chk("reset_valid", 64'(data_output_valid), 64'(0));
    chk("reset_dout", data_64_out, 64'(0));

    tick(1'b1, 64'h0, 1'b0); drain();
    chk("kat_key0", data_64_out, 64'h8CA64DE9C1B123A7);

    load_key(64'h133457799BBCDFF1, 1'b1, 1'b1);
    tick(1'b1, 64'h0123456789ABCDEF, 1'b0); drain();
    chk("kat_enc", data_64_out, 64'h85E813540F0AB405);

    ov_cnt = 0;
    tick(1'b1, 64'h0123456789ABCDEF, 1'b0);
    tick(1'b1, 64'h0123456789AB0000, 1'b0);
    drain();
    chk("burst_len", 64'(ov_cnt), 64'(2));
    chk("burst_2nd", data_64_out, des_ref(64'h133457799BBCDFF1, 64'h0123456789AB0000, 1'b1));
    ct2 = data_64_out;

    load_key(64'h133457799BBCDFF1, 1'b0, 1'b0);
    tick(1'b1, 64'h85E813540F0AB405, 1'b0); drain();
    chk("kat_dec", data_64_out, 64'h0123456789ABCDEF);
    tick(1'b1, ct2, 1'b0); drain();
    chk("round_trip", data_64_out, 64'h0123456789AB0000);

    for (int k = 0; k < 3; k++) begin
      load_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'(k == 1));
      for (int i = 0; i < 40; i++) tick($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'b0);
      drain();
    end

    // reset while the scheduler is mid-GEN
    keys_64_in = {$urandom, $urandom}; encrypt = 1'b0;
    tick(1'b0, '0, 1'b1); kv_exp = 1'b0;
    repeat (5) tick(1'b0, '0, 1'b0);
    async_rst();
    tick(1'b1, 64'h0, 1'b0); drain();
    chk("kat_key0_gen_rst", data_64_out, 64'h8CA64DE9C1B123A7);

    // reset while results are streaming out
    for (int i = 0; i < 20; i++) tick(1'b1, {$urandom, $urandom}, 1'b0);
    async_rst();
    tick(1'b1, 64'h0, 1'b0); drain();
    chk("kat_key0_burst_rst", data_64_out, 64'h8CA64DE9C1B123A7);

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
